// File: rtl/pwm_breathe_multi.sv
`default_nettype none
// ============================================================================
// Module      : pwm_breathe_multi
// Description : Multi-channel PWM generator with four modes (OFF, FIXED 50%,
//               BREATHE ramp with antiphase odd channels, CHASE single lit
//               channel). All channels share one period counter; period and
//               per-channel duty are shadowed and only change at period wrap,
//               so no output ever sees a torn period.
// Ports       : clk       - sole clock, rising edge
//               rst_n     - asynchronous active-low reset
//               period    - PWM period in clk cycles (0 = outputs held low)
//               step      - BREATHE duty change per ramp tick
//               mode_step - one-cycle pulse, advances OFF->FIXED->BREATHE->CHASE
//               ch_en     - per-channel output enable
//               pwm_out   - registered PWM outputs
//               mode      - current mode (0 OFF, 1 FIXED, 2 BREATHE, 3 CHASE)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_breathe_multi #(
   parameter int CH       = 4,
   parameter int W        = 16,
   parameter int RAMP_DIV = 50000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  period,
   input  logic [W-1:0]  step,
   input  logic          mode_step,
   input  logic [CH-1:0] ch_en,
   output logic [CH-1:0] pwm_out,
   output logic [1:0]    mode
);

   localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
   localparam int PS_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_FIXED   = 2'd1;
   localparam logic [1:0] MODE_BREATHE = 2'd2;
   localparam logic [1:0] MODE_CHASE   = 2'd3;

   localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(RAMP_DIV - 1);
   localparam logic [PS_W-1:0]  PS_ONE   = {{(PS_W-1){1'b0}}, 1'b1};
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // Shared period counter and period shadow
   // ------------------------------------------------------------------------
   logic [W-1:0] cnt;
   logic [W-1:0] shadow_period;
   logic         period_zero;
   logic         at_wrap;
   logic         shadow_load;

   assign period_zero = (shadow_period == '0);
   assign at_wrap     = !period_zero && (cnt == (shadow_period - ONE_W));
   // A zero shadow period never wraps, so it reloads every cycle instead;
   // otherwise a period of 0 could never be left.
   assign shadow_load = at_wrap || period_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt           <= '0;
         shadow_period <= '0;
      end else begin
         if (at_wrap || period_zero) cnt <= '0;
         else                        cnt <= cnt + ONE_W;
         if (shadow_load) shadow_period <= period;
      end
   end

   // ------------------------------------------------------------------------
   // Mode state machine
   // ------------------------------------------------------------------------
   logic [1:0] state;
   logic [1:0] state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MODE_OFF;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (mode_step) begin
         case (state)
            MODE_OFF:     state_next = MODE_FIXED;
            MODE_FIXED:   state_next = MODE_BREATHE;
            MODE_BREATHE: state_next = MODE_CHASE;
            default:      state_next = MODE_OFF;
         endcase
      end
   end

   always_comb begin
      mode = state;
   end

   // ------------------------------------------------------------------------
   // Ramp prescaler: restarted on every mode change so each mode begins with
   // a full tick interval.
   // ------------------------------------------------------------------------
   logic [PS_W-1:0] presc;
   logic            ramp_tick;

   assign ramp_tick = (presc == PS_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      presc <= '0;
      else if (mode_step || ramp_tick) presc <= '0;
      else                             presc <= presc + PS_ONE;
   end

   // ------------------------------------------------------------------------
   // BREATHE accumulator. The sum is formed one bit wider so a large step
   // near the top of the range saturates at the period instead of wrapping.
   // ------------------------------------------------------------------------
   logic [W-1:0] duty_acc;
   logic         dir_up;
   logic [W:0]   acc_ext;
   logic [W:0]   step_ext;
   logic [W:0]   sp_ext;
   logic [W:0]   sum_ext;
   logic [W-1:0] acc_ramp;
   logic         dir_ramp;
   logic [W-1:0] acc_next;
   logic         dir_next;

   always_comb begin
      acc_ext  = {1'b0, duty_acc};
      step_ext = {1'b0, step};
      sp_ext   = {1'b0, shadow_period};
      sum_ext  = acc_ext + step_ext;
      acc_ramp = duty_acc;
      dir_ramp = dir_up;
      if (dir_up) begin
         if (sum_ext >= sp_ext) begin
            acc_ramp = shadow_period;
            dir_ramp = 1'b0;
         end else begin
            acc_ramp = sum_ext[W-1:0];
         end
      end else begin
         if (step_ext >= acc_ext) begin
            acc_ramp = '0;
            dir_ramp = 1'b1;
         end else begin
            acc_ramp = duty_acc - step;
         end
      end
   end

   // A mode change wins over a coincident tick; the clamp keeps the
   // accumulator inside a newly shortened period.
   always_comb begin
      acc_next = duty_acc;
      dir_next = dir_up;
      if (mode_step) begin
         acc_next = '0;
         dir_next = 1'b1;
      end else if (ramp_tick && (state == MODE_BREATHE)) begin
         acc_next = acc_ramp;
         dir_next = dir_ramp;
      end
      if (shadow_load && (acc_next > period)) acc_next = period;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_acc <= '0;
         dir_up   <= 1'b1;
      end else begin
         duty_acc <= acc_next;
         dir_up   <= dir_next;
      end
   end

   // ------------------------------------------------------------------------
   // CHASE index
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx <= '0;
      end else if (mode_step) begin
         idx <= '0;
      end else if (ramp_tick && (state == MODE_CHASE)) begin
         idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Per-channel targets, duty shadows and compare
   // ------------------------------------------------------------------------
   // Targets are built from the live period so the duty loaded at a wrap
   // matches the period loaded at the same edge.
   logic [W-1:0]  acc_lim;
   logic [W-1:0]  half_period;
   logic [CH-1:0] pwm_next;

   assign acc_lim     = (duty_acc > period) ? period : duty_acc;
   assign half_period = period >> 1;

   for (genvar k = 0; k < CH; k++) begin : g_ch
      logic [W-1:0] target;
      logic [W-1:0] shadow_duty;

      always_comb begin
         target = '0;
         case (state)
            MODE_FIXED: target = half_period;
            MODE_BREATHE: begin
               if ((k % 2) == 0) target = acc_lim;
               else              target = period - acc_lim;
            end
            MODE_CHASE: target = (idx == IDX_W'(k)) ? period : '0;
            default:    target = '0;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)       shadow_duty <= '0;
         else if (at_wrap) shadow_duty <= target;
      end

      // Duty >= period gives a constant high; a zero period forces low even
      // if a stale non-zero duty is still shadowed.
      assign pwm_next[k] = ch_en[k] & ~period_zero & (cnt < shadow_duty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pwm_out <= '0;
      else        pwm_out <= pwm_next;
   end

endmodule
`default_nettype wire

// File: doc/pwm_breathe_multi.md
PWM_BREATHE_MULTI -- requirements
Module: pwm_breathe_multi

Interface
REQ-001 SHALL have parameter CH, default 4: number of PWM channels (1..16).
REQ-002 SHALL have parameter W, default 16: width of period, step and duty arithmetic.
REQ-003 SHALL have parameter RAMP_DIV, default 50000: clk cycles per ramp tick (>=1).
REQ-004 SHALL have port clk  input  1: sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port period  input  W: PWM period in clk cycles, shared by all channels.
REQ-007 SHALL have port step  input  W: duty increment/decrement per ramp tick in BREATHE mode.
REQ-008 SHALL have port mode_step  input  1: single-cycle pulse, already debounced and synchronous; advances mode.
REQ-009 SHALL have port ch_en  input  CH: per-channel output enable.
REQ-010 SHALL have port pwm_out  output  CH: PWM outputs.
REQ-011 SHALL have port mode  output  2: current mode, 0=OFF, 1=FIXED, 2=BREATHE, 3=CHASE.

Function
REQ-012 SHALL run a shared period counter cnt: 0..period-1, wraps to 0; period=0 holds cnt at 0.
REQ-013 SHALL sample period into a shadow register only at wrap (cnt = shadow_period-1) or while shadow_period=0.
REQ-014 SHALL sample each channel's target duty into a per-channel shadow duty only at wrap; no mid-period duty change.
REQ-015 SHALL drive pwm_out[k] = ch_en[k] AND (cnt < shadow_duty[k]), registered (one cycle after cnt).
REQ-016 SHALL give constant-high output for duty >= period and constant-low for duty = 0 or period = 0.
REQ-017 SHALL run a prescaler 0..RAMP_DIV-1, issuing a one-cycle ramp tick on wrap.
REQ-018 SHALL advance mode on mode_step: OFF->FIXED->BREATHE->CHASE->OFF; mode output updates next cycle.
REQ-019 SHALL, on every mode change, clear duty_acc to 0, set dir=up, clear chase index and prescaler.
REQ-020 SHALL give mode_step precedence over a ramp tick in the same cycle (tick discarded).
REQ-021 OFF: all channel target duties = 0.
REQ-022 FIXED: all channel target duties = period >> 1.
REQ-023 BREATHE: per tick, dir=up: duty_acc = min(duty_acc+step, period), flip to down on reaching period; dir=down: duty_acc = max(duty_acc-step, 0), flip to up on reaching 0.
REQ-024 BREATHE SHALL compute in W+1 bits; no wrap-around for any step/period values.
REQ-025 BREATHE: even channels target duty_acc; odd channels target period - duty_acc (antiphase).
REQ-026 BREATHE with step=0 SHALL hold duty_acc constant.
REQ-027 CHASE: channel idx targets period, all others 0; idx advances each tick, CH-1 wraps to 0.
REQ-028 SHALL clamp duty_acc to the new period when period drops below duty_acc (at shadow update).

Reset
REQ-029 SHALL on rst_n low asynchronously clear cnt, prescaler, all shadows, duty_acc, chase idx; set dir=up, mode=OFF, pwm_out=0.
REQ-030 SHALL resume from these values on the first clk edge after rst_n deasserts; reset mid-operation discards all state.

Verification (CH=4, W=8, RAMP_DIV=4)
REQ-031 Reset asserted mid-BREATHE -> pwm_out=0000 and mode=0 immediately, without waiting for clk.
REQ-032 period=10, ch_en=1111, one mode_step -> mode=1; after first wrap each channel high 5 of every 10 cycles.
REQ-033 BREATHE, period=10, step=3 -> duty_acc per tick 0,3,6,9,10,7,4,1,0,3; channel 1 targets 10,7,4,1,0,3,...
REQ-034 CHASE, period=10 -> only idx channel constantly high; idx 0,1,2,3,0 every 4 cycles; ch_en=1011 keeps pwm_out[2] low.
REQ-035 period changed 10->6 mid-period -> new period takes effect only after cnt reaches 9; duty_acc=9 clamped to 6.
REQ-036 mode_step coincident with ramp tick in BREATHE -> mode=3, idx=0, duty_acc=0; tick has no effect.
